sprite_frame_sched: RTL and testbench

SPRITE_FRAME_SCHED -- requirements
Module: sprite_frame_sched

---
 rtl/sprite_frame_sched_pkg.sv | 38 +++
 rtl/sprite_frame_sched_rr_arb2.sv | 17 +
 rtl/sprite_frame_sched.sv | 144 ++++++++++++++
 tb/tb_sprite_frame_sched.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_frame_sched_pkg.sv
// Shared types and constants for the sprite frame scheduler.
// Optional row clamping is enabled by defining SPRITE_CLAMP_EN.
package sprite_frame_sched_pkg;

  localparam int unsigned CNT_W   = 11;
  localparam int unsigned XY_W    = 10;
  localparam int unsigned ROW_W   = 5;
  localparam int unsigned COLOR_W = 12;
  localparam int unsigned FRAME_W = 8;
  localparam int unsigned N_REQ   = 2;

  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned Y_MAX_DEF    = 18;
  localparam int unsigned ROW_PITCH    = 24;
  localparam int unsigned SPRITE_H     = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARB    = 2'd1,
    ST_HOLD   = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  typedef struct packed {
    logic [XY_W-1:0]    xypos;
    logic [COLOR_W-1:0] color;
  } sprite_t;

  // Saturate the row field (low bits) to ymax, leaving the column untouched.
  function automatic logic [XY_W-1:0] clamp_row(input logic [XY_W-1:0] xy,
                                                input logic [ROW_W-1:0] ymax);
    logic [ROW_W-1:0] row;
    row = xy[ROW_W-1:0];
    if (row > ymax) row = ymax;
    return {xy[XY_W-1:ROW_W], row};
  endfunction

endpackage

// File: rtl/sprite_frame_sched_rr_arb2.sv
// Two-way round-robin grant: pointer=1 means requester 1 was granted last,
// so requester 0 is preferred on a tie.
module rr_arb2
  import sprite_frame_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic             pointer,
  output logic [N_REQ-1:0] grant
);

  logic w_tie;

  assign w_tie    = req[0] & req[1];
  assign grant[0] = req[0] & (~w_tie | pointer);
  assign grant[1] = req[1] & (~w_tie | ~pointer);

endmodule

// File: rtl/sprite_frame_sched.sv
// Double-buffered sprite position/colour: requests land in a shadow register and
// are committed to the live outputs only at the end of active video.
// Optional feature macro: SPRITE_CLAMP_EN (saturate sprite row to Y_MAX).
module sprite_frame_sched
  import sprite_frame_sched_pkg::*;
#(
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned Y_MAX    = Y_MAX_DEF
) (
  input  logic                 pixel_clk,
  input  logic                 rst,
  input  logic [CNT_W-1:0]     hcount,
  input  logic [CNT_W-1:0]     vcount,
  input  logic                 cpu_req,
  input  logic [XY_W-1:0]      cpu_xypos,
  input  logic [COLOR_W-1:0]   cpu_color,
  output logic                 cpu_ack,
  input  logic                 aux_req,
  input  logic [XY_W-1:0]      aux_xypos,
  input  logic [COLOR_W-1:0]   aux_color,
  output logic                 aux_ack,
  output logic [XY_W-1:0]      live_xypos,
  output logic [COLOR_W-1:0]   live_color,
  output logic                 pending,
  output logic [FRAME_W-1:0]   frame_cnt
);

  if (Y_MAX * ROW_PITCH + SPRITE_H > V_ACTIVE) begin : g_bad_layout
    $error("sprite_frame_sched: lowest sprite row extends past active video");
  end

  state_t               r_state;
  state_t               w_next;
  logic                 r_last;
  sprite_t              r_shadow;
  sprite_t              r_live;
  logic                 r_cpu_ack;
  logic                 r_aux_ack;
  logic                 r_pending;
  logic [FRAME_W-1:0]   r_frame_cnt;

  logic [N_REQ-1:0]     w_grant;
  logic                 w_any_req;
  logic                 w_commit_pt;
  logic                 w_load;
  logic                 w_cpu_grant;
  logic                 w_aux_grant;
  logic                 w_commit;
  logic [XY_W-1:0]      w_sel_xy;
  logic [COLOR_W-1:0]   w_sel_color;
  sprite_t              w_store;

  assign w_any_req   = cpu_req | aux_req;
  assign w_commit_pt = (vcount == CNT_W'(V_ACTIVE)) && (hcount == '0);

  rr_arb2 u_arb (
    .req     ({aux_req, cpu_req}),
    .pointer (r_last),
    .grant   (w_grant)
  );

  assign w_sel_xy    = w_grant[1] ? aux_xypos : cpu_xypos;
  assign w_sel_color = w_grant[1] ? aux_color : cpu_color;

  // State register
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; a request dropped before ARB sends the FSM back to IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_any_req) w_next = ST_ARB;
      ST_ARB:    w_next = w_any_req ? ST_HOLD : ST_IDLE;
      ST_HOLD:   if (w_commit_pt) w_next = ST_COMMIT;
      ST_COMMIT: w_next = w_any_req ? ST_ARB : ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Per-state control strobes
  always_comb begin
    w_load      = 1'b0;
    w_cpu_grant = 1'b0;
    w_aux_grant = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_ARB: begin
        w_load      = w_any_req;
        w_cpu_grant = w_grant[0];
        w_aux_grant = w_grant[1];
      end
      ST_COMMIT: w_commit = 1'b1;
      default: ;
    endcase
  end

  // Value captured into the shadow register
  always_comb begin
    w_store.color = w_sel_color;
`ifdef SPRITE_CLAMP_EN
    w_store.xypos = clamp_row(w_sel_xy, ROW_W'(Y_MAX));
`else
    w_store.xypos = w_sel_xy;
`endif
  end

  // Shadow/live datapath, acks, pending flag and frame counter
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_last      <= 1'b1;
      r_shadow    <= '0;
      r_live      <= '0;
      r_cpu_ack   <= 1'b0;
      r_aux_ack   <= 1'b0;
      r_pending   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_cpu_ack <= w_cpu_grant;
      r_aux_ack <= w_aux_grant;
      if (w_load) begin
        r_shadow <= w_store;
        r_last   <= ~r_last;
      end
      if (w_commit) begin
        r_pending   <= 1'b0;
        r_live      <= r_shadow;
        r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
      end else if (r_cpu_ack | r_aux_ack) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign cpu_ack    = r_cpu_ack;
  assign aux_ack    = r_aux_ack;
  assign live_xypos = r_live.xypos;
  assign live_color = r_live.color;
  assign pending    = r_pending;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_sprite_frame_sched.sv
// Directed bench for sprite_frame_sched: commit timing, arbitration, reset, clamp, wrap.
module tb_sprite_frame_sched;

`ifdef SPRITE_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount = '0;
  logic [10:0] vcount = '0;
  logic        cpu_req = 1'b0;
  logic [9:0]  cpu_xypos = '0;
  logic [11:0] cpu_color = '0;
  logic        aux_req = 1'b0;
  logic [9:0]  aux_xypos = '0;
  logic [11:0] aux_color = '0;
  logic        cpu_ack, aux_ack, pending;
  logic [9:0]  live_xypos;
  logic [11:0] live_color;
  logic [7:0]  frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  sprite_frame_sched dut (
    .pixel_clk (clk),
    .rst       (rst),
    .hcount    (hcount),
    .vcount    (vcount),
    .cpu_req   (cpu_req),
    .cpu_xypos (cpu_xypos),
    .cpu_color (cpu_color),
    .cpu_ack   (cpu_ack),
    .aux_req   (aux_req),
    .aux_xypos (aux_xypos),
    .aux_color (aux_color),
    .aux_ack   (aux_ack),
    .live_xypos(live_xypos),
    .live_color(live_color),
    .pending   (pending),
    .frame_cnt (frame_cnt)
  );

  always #20 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    cpu_req = 1'b0;
    aux_req = 1'b0;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    tick;
  endtask

  // Cycles until the selected ack is seen, or -1 after a bounded wait
  task automatic wait_ack(input bit aux, output int n);
    n = -1;
    for (int i = 1; i <= 8; i++) begin
      tick;
      if ((aux ? aux_ack : cpu_ack) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic commit_frame;
    vcount = 11'd480;
    hcount = 11'd0;
    tick;
    hcount = 11'd1;
    tick;
    vcount = 11'd481;
    hcount = 11'd2;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    n_tests++; if (live_xypos !== 10'h0) begin n_fail++; $display("FAIL reset_live_xypos got=%0h exp=0", live_xypos); end
    n_tests++; if (live_color !== 12'h0) begin n_fail++; $display("FAIL reset_live_color got=%0h exp=0", live_color); end
    n_tests++; if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got=%0h exp=0", pending); end
    n_tests++; if (frame_cnt !== 8'h0) begin n_fail++; $display("FAIL reset_frame_cnt got=%0h exp=0", frame_cnt); end
    n_tests++; if ({cpu_ack, aux_ack} !== 2'b00) begin n_fail++; $display("FAIL reset_acks got=%0b exp=00", {cpu_ack, aux_ack}); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    int n;
    vcount = 11'd100; hcount = 11'd0;
    cpu_xypos = 10'h210; cpu_color = 12'hF00; cpu_req = 1'b1;
    wait_ack(1'b0, n);
    n_tests++; if (n !== 2) begin n_fail++; $display("FAIL basic_ack_latency got=%0d exp=2", n); end
    n_tests++; if (aux_ack !== 1'b0) begin n_fail++; $display("FAIL basic_aux_ack got=%0h exp=0", aux_ack); end
    n_tests++; if (pending !== 1'b0) begin n_fail++; $display("FAIL basic_pending_in_ack got=%0h exp=0", pending); end
    cpu_req = 1'b0;
    tick;
    n_tests++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL basic_ack_width got=%0h exp=0", cpu_ack); end
    n_tests++; if (pending !== 1'b1) begin n_fail++; $display("FAIL basic_pending_set got=%0h exp=1", pending); end
    vcount = 11'd300;
    repeat (3) tick;
    n_tests++; if ({live_xypos, live_color} !== 22'h0) begin n_fail++; $display("FAIL basic_live_early got=%0h exp=0", {live_xypos, live_color}); end
    vcount = 11'd480; hcount = 11'd0;
    tick;
    n_tests++; if (pending !== 1'b1) begin n_fail++; $display("FAIL basic_pending_commit got=%0h exp=1", pending); end
    n_tests++; if (live_xypos !== 10'h0) begin n_fail++; $display("FAIL basic_live_in_commit got=%0h exp=0", live_xypos); end
    hcount = 11'd1;
    tick;
    n_tests++; if (live_xypos !== 10'h210) begin n_fail++; $display("FAIL basic_live_xypos got=%0h exp=210", live_xypos); end
    n_tests++; if (live_color !== 12'hF00) begin n_fail++; $display("FAIL basic_live_color got=%0h exp=f00", live_color); end
    n_tests++; if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL basic_frame_cnt got=%0d exp=1", frame_cnt); end
    n_tests++; if (pending !== 1'b0) begin n_fail++; $display("FAIL basic_pending_clear got=%0h exp=0", pending); end
    vcount = 11'd481; hcount = 11'd2;
  endtask

  task automatic test_drop;
    int acks;
    acks = 0;
    vcount = 11'd50; hcount = 11'd0;
    cpu_xypos = 10'h3FF; cpu_color = 12'hABC; cpu_req = 1'b1;
    tick;
    cpu_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (cpu_ack === 1'b1 || aux_ack === 1'b1) acks++;
    end
    n_tests++; if (acks !== 0) begin n_fail++; $display("FAIL drop_acks got=%0d exp=0", acks); end
    n_tests++; if (pending !== 1'b0) begin n_fail++; $display("FAIL drop_pending got=%0h exp=0", pending); end
    commit_frame;
    n_tests++; if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL drop_frame_cnt got=%0d exp=1", frame_cnt); end
    n_tests++; if (live_xypos !== 10'h210) begin n_fail++; $display("FAIL drop_live got=%0h exp=210", live_xypos); end
  endtask

  task automatic test_both;
    int n;
    int aux_seen;
    apply_reset;
    vcount = 11'd10; hcount = 11'd0;
    cpu_xypos = 10'h145; cpu_color = 12'h00F;
    aux_xypos = 10'h0A3; aux_color = 12'h0F0;
    cpu_req = 1'b1; aux_req = 1'b1;
    wait_ack(1'b0, n);
    n_tests++; if (n !== 2) begin n_fail++; $display("FAIL both_cpu_first got=%0d exp=2", n); end
    n_tests++; if (aux_ack !== 1'b0) begin n_fail++; $display("FAIL both_aux_not_acked got=%0h exp=0", aux_ack); end
    cpu_req = 1'b0;
    aux_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (aux_ack === 1'b1) aux_seen++;
    end
    n_tests++; if (aux_seen !== 0) begin n_fail++; $display("FAIL both_hold_no_ack got=%0d exp=0", aux_seen); end
    commit_frame;
    n_tests++; if ({live_xypos, live_color} !== {10'h145, 12'h00F}) begin n_fail++; $display("FAIL both_frame_n got=%0h exp=%0h", {live_xypos, live_color}, {10'h145, 12'h00F}); end
    n_tests++; if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL both_frame_n_cnt got=%0d exp=1", frame_cnt); end
    wait_ack(1'b1, n);
    n_tests++; if (n !== 1) begin n_fail++; $display("FAIL both_aux_ack got=%0d exp=1", n); end
    aux_req = 1'b0;
    commit_frame;
    n_tests++; if ({live_xypos, live_color} !== {10'h0A3, 12'h0F0}) begin n_fail++; $display("FAIL both_frame_n1 got=%0h exp=%0h", {live_xypos, live_color}, {10'h0A3, 12'h0F0}); end
    n_tests++; if (frame_cnt !== 8'd2) begin n_fail++; $display("FAIL both_frame_n1_cnt got=%0d exp=2", frame_cnt); end
  endtask

  task automatic test_late;
    int n;
    vcount = 11'd480; hcount = 11'd5;
    cpu_xypos = 10'h2C4; cpu_color = 12'h555; cpu_req = 1'b1;
    wait_ack(1'b0, n);
    n_tests++; if (n !== 2) begin n_fail++; $display("FAIL late_ack got=%0d exp=2", n); end
    cpu_req = 1'b0;
    vcount = 11'd0; hcount = 11'd0;
    tick;
    vcount = 11'd200;
    tick;
    n_tests++; if (pending !== 1'b1) begin n_fail++; $display("FAIL late_pending got=%0h exp=1", pending); end
    n_tests++; if (live_xypos !== 10'h0A3) begin n_fail++; $display("FAIL late_live_early got=%0h exp=a3", live_xypos); end
    n_tests++; if (frame_cnt !== 8'd2) begin n_fail++; $display("FAIL late_no_commit got=%0d exp=2", frame_cnt); end
    commit_frame;
    n_tests++; if ({live_xypos, live_color} !== {10'h2C4, 12'h555}) begin n_fail++; $display("FAIL late_commit got=%0h exp=%0h", {live_xypos, live_color}, {10'h2C4, 12'h555}); end
    n_tests++; if (frame_cnt !== 8'd3) begin n_fail++; $display("FAIL late_frame_cnt got=%0d exp=3", frame_cnt); end
  endtask

  task automatic test_reset_mid_hold;
    int n;
    vcount = 11'd100; hcount = 11'd0;
    cpu_xypos = 10'h1FF; cpu_color = 12'hFFF; cpu_req = 1'b1;
    wait_ack(1'b0, n);
    cpu_req = 1'b0;
    tick;
    n_tests++; if (pending !== 1'b1) begin n_fail++; $display("FAIL rsthold_pending_pre got=%0h exp=1", pending); end
    rst = 1'b1;
    #1;
    n_tests++; if ({live_xypos, live_color} !== 22'h0) begin n_fail++; $display("FAIL rsthold_live_async got=%0h exp=0", {live_xypos, live_color}); end
    n_tests++; if (pending !== 1'b0) begin n_fail++; $display("FAIL rsthold_pending_async got=%0h exp=0", pending); end
    tick;
    rst = 1'b0;
    tick;
    commit_frame;
    n_tests++; if ({live_xypos, live_color} !== 22'h0) begin n_fail++; $display("FAIL rsthold_no_commit got=%0h exp=0", {live_xypos, live_color}); end
    n_tests++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL rsthold_frame_cnt got=%0d exp=0", frame_cnt); end
    n_tests++; if (pending !== 1'b0) begin n_fail++; $display("FAIL rsthold_pending_post got=%0h exp=0", pending); end
  endtask

  task automatic test_clamp;
    int n;
    logic [9:0] exp_xy;
    vcount = 11'd100; hcount = 11'd0;
    cpu_xypos = {5'd3, 5'd31}; cpu_color = 12'h123; cpu_req = 1'b1;
    wait_ack(1'b0, n);
    cpu_req = 1'b0;
    commit_frame;
    exp_xy = CLAMP ? {5'd3, 5'd18} : {5'd3, 5'd31};
    n_tests++; if (live_xypos !== exp_xy) begin n_fail++; $display("FAIL clamp_row31 got=%0h exp=%0h", live_xypos, exp_xy); end
    vcount = 11'd100;
    cpu_xypos = {5'd7, 5'd19}; cpu_req = 1'b1;
    wait_ack(1'b0, n);
    cpu_req = 1'b0;
    commit_frame;
    exp_xy = CLAMP ? {5'd7, 5'd18} : {5'd7, 5'd19};
    n_tests++; if (live_xypos !== exp_xy) begin n_fail++; $display("FAIL clamp_row19 got=%0h exp=%0h", live_xypos, exp_xy); end
    vcount = 11'd100;
    cpu_xypos = {5'd31, 5'd18}; cpu_req = 1'b1;
    wait_ack(1'b0, n);
    cpu_req = 1'b0;
    commit_frame;
    n_tests++; if (live_xypos !== {5'd31, 5'd18}) begin n_fail++; $display("FAIL clamp_row18 got=%0h exp=%0h", live_xypos, {5'd31, 5'd18}); end
  endtask

  task automatic test_wrap;
    int n;
    int timeouts;
    timeouts = 0;
    apply_reset;
    for (int i = 0; i < 256; i++) begin
      vcount = 11'd100; hcount = 11'd0;
      cpu_xypos = 10'(i); cpu_color = 12'(i * 3); cpu_req = 1'b1;
      wait_ack(1'b0, n);
      if (n < 0) timeouts++;
      cpu_req = 1'b0;
      commit_frame;
      if (i == 254) begin
        n_tests++; if (frame_cnt !== 8'd255) begin n_fail++; $display("FAIL wrap_cnt_255 got=%0d exp=255", frame_cnt); end
      end
    end
    n_tests++; if (timeouts !== 0) begin n_fail++; $display("FAIL wrap_ack_timeouts got=%0d exp=0", timeouts); end
    n_tests++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL wrap_cnt_0 got=%0d exp=0", frame_cnt); end
    n_tests++; if ({live_xypos, live_color} !== {10'd255, 12'd765}) begin n_fail++; $display("FAIL wrap_last_live got=%0h exp=%0h", {live_xypos, live_color}, {10'd255, 12'd765}); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_drop;
    test_both;
    test_late;
    test_reset_mid_hold;
    test_clamp;
    test_wrap;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
